// File: rtl/saida_tracer.sv
// saida_tracer
//   Watches the CODE_W-bit state code from the upstream FSM and logs every
//   change as an {code, interval} entry in a DEPTH-entry FIFO drained through
//   a valid/ready port. Also pulses seq_hit one cycle after the event
//   sequence 5, 6, 3.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   saida      : incoming state code, sampled when en=1
//   en         : capture enable; en=0 freezes prev/cnt and blocks events
//   out_ready  : consumer accepts the head entry
//   out_valid  : FIFO non-empty
//   out_code   : head entry code (0 when empty)
//   out_dt     : head entry interval in enabled cycles (0 when empty)
//   count      : number of stored entries
//   overflow   : sticky, an event was dropped on a full FIFO
//   seq_hit    : one-cycle pulse after events 5, 6, 3
module saida_tracer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CODE_W = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CODE_W-1:0]          saida,
   input  logic                       en,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [CODE_W-1:0]          out_code,
   output logic [7:0]                 out_dt,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       seq_hit
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [CODE_W-1:0] CODE_5   = CODE_W'(5);
   localparam logic [CODE_W-1:0] CODE_6   = CODE_W'(6);
   localparam logic [CODE_W-1:0] CODE_3   = CODE_W'(3);

   logic [CODE_W-1:0] prev;
   logic [7:0]        cnt;
   logic [CODE_W-1:0] hist_old;   // code of the event before the last one
   logic [CODE_W-1:0] hist_new;   // code of the last event
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [CODE_W-1:0] mem_code [DEPTH];
   logic [7:0]        mem_dt   [DEPTH];

   logic       ev;
   logic       full;
   logic       pop;
   logic       push;
   logic       drop;
   logic [7:0] cnt_sat;

   always_comb begin
      ev      = en && (saida != prev);
      full    = (count == FULL_CNT);
      pop     = out_valid && out_ready;
      // a pop on a full FIFO frees the slot the new entry needs this same edge
      push    = ev && (!full || pop);
      drop    = ev && full && !pop;
      cnt_sat = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
   end

   always_comb begin
      out_valid = (count != '0);
      out_code  = out_valid ? mem_code[rd_ptr] : '0;
      out_dt    = out_valid ? mem_dt[rd_ptr]   : '0;
   end

   // storage needs no reset: entries are only read while counted as valid
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_code[wr_ptr] <= saida;
         mem_dt[wr_ptr]   <= cnt_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev     <= '0;
         cnt      <= '0;
         hist_old <= '0;
         hist_new <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         seq_hit  <= 1'b0;
      end else begin
         seq_hit <= 1'b0;
         if (en) begin
            prev <= saida;
            cnt  <= ev ? 8'd0 : cnt_sat;
         end
         // dropped events still advance the detector history
         if (ev) begin
            seq_hit  <= (hist_old == CODE_5) && (hist_new == CODE_6) && (saida == CODE_3);
            hist_old <= hist_new;
            hist_new <= saida;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_saida_tracer.sv
// Testbench for saida_tracer: directed phases followed by randomized traffic,
// checked against a transaction-level model through an expected-entry queue.
module tb_saida_tracer;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] saida = '0;
   logic       en = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_code;
   logic [7:0] out_dt;
   logic [3:0] count;
   logic       overflow;
   logic       seq_hit;

   saida_tracer #(.DEPTH(DEPTH), .CODE_W(3)) dut (
      .clk(clk), .reset(reset), .saida(saida), .en(en), .out_ready(out_ready),
      .out_valid(out_valid), .out_code(out_code), .out_dt(out_dt),
      .count(count), .overflow(overflow), .seq_hit(seq_hit)
   );

   always #5 clk = ~clk;

   typedef struct { int code; int dt; } ent_t;
   ent_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_prev = 0, m_cnt = 0, m_count = 0, m_ovf = 0, m_seq = 0;
   int m_events[$];   // codes of all events since reset

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input int r, input int e, input int s, input int rd);
      int popv, pushv, dt, n;
      if (r != 0) begin
         m_prev = 0; m_cnt = 0; m_count = 0; m_ovf = 0; m_seq = 0;
         exp_q.delete();
         m_events.delete();
         return;
      end
      popv  = (m_count > 0 && rd != 0) ? 1 : 0;
      pushv = 0;
      m_seq = 0;
      if (e != 0) begin
         if (s != m_prev) begin
            dt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            if (m_count < DEPTH || popv == 1) begin
               pushv = 1;
               exp_q.push_back('{code: s, dt: dt});
            end else begin
               m_ovf = 1;
            end
            m_events.push_back(s);
            n = m_events.size();
            if (n >= 3 && m_events[n-3] == 5 && m_events[n-2] == 6 && m_events[n-1] == 3)
               m_seq = 1;
            m_cnt = 0;
         end else begin
            m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         end
         m_prev = s;
      end
      m_count = m_count + pushv - popv;
   endtask

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   // compare registered state with the model, then drive the next edge's inputs
   task automatic drive(input int r, input int e, input int s, input int rd);
      check("count",     int'(count),     m_count);
      check("overflow",  int'(overflow),  m_ovf);
      check("seq_hit",   int'(seq_hit),   m_seq);
      check("out_valid", int'(out_valid), (m_count > 0) ? 1 : 0);
      reset     = (r != 0);
      en        = (e != 0);
      saida     = 3'(s);
      out_ready = (rd != 0);
      model_edge(r, e, s, rd);
   endtask

   task automatic step(input int r, input int e, input int s, input int rd);
      sync();
      drive(r, e, s, rd);
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, int'(saida), 1);
   endtask

   // monitor: pops the expected entry whenever the DUT hands one over
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!out_valid) begin
            check("idle_code", int'(out_code), 0);
            check("idle_dt",   int'(out_dt),   0);
         end else if (out_ready && !reset) begin
            if (exp_q.size() == 0) begin
               check("unexpected_entry", int'(out_code), -1);
            end else begin
               e = exp_q.pop_front();
               check("entry_code", int'(out_code), e.code);
               check("entry_dt",   int'(out_dt),   e.dt);
            end
         end
      end
   end

   initial begin
      int s, v;
      // reset and first events
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      sync();
      check("rst_valid", int'(out_valid), 0);
      check("rst_count", int'(count), 0);
      drive(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      sync();
      check("first_code", int'(out_code), 1);
      check("first_dt",   int'(out_dt), 4);
      check("first_cnt",  int'(count), 1);
      drive(0, 0, 1, 1);
      drain(2);

      // sequence detection, twice
      step(1, 0, 0, 0);
      step(0, 1, 5, 0);
      step(0, 1, 6, 0);
      step(0, 1, 3, 0);
      sync();
      check("seq_pulse1", int'(seq_hit), 1);
      drive(0, 1, 5, 0);
      sync();
      check("seq_clear", int'(seq_hit), 0);
      drive(0, 1, 6, 0);
      step(0, 1, 3, 0);
      sync();
      check("seq_pulse2", int'(seq_hit), 1);
      check("seq_count",  int'(count), 6);
      drive(0, 0, 3, 1);
      drain(7);

      // overflow
      step(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, (i % 7) + 1, 0);
      sync();
      check("ovf_count", int'(count), 8);
      check("ovf_flag",  int'(overflow), 1);
      drive(0, 0, 2, 1);
      drain(9);
      sync();
      check("ovf_sticky", int'(overflow), 1);
      drive(0, 0, 2, 0);

      // simultaneous push and pop while full
      step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, (i % 7) + 1, 0);
      step(0, 1, 0, 1);
      sync();
      check("full_pp_count", int'(count), 8);
      check("full_pp_ovf",   int'(overflow), 0);
      drive(0, 0, 0, 1);
      drain(9);

      // interval saturation with en toggling
      step(1, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         step(0, 0, $urandom_range(1, 7), 1);
         step(0, 1, 0, 1);
      end
      step(0, 1, 2, 0);
      sync();
      check("sat_dt",    int'(out_dt), 255);
      check("sat_count", int'(count), 1);
      drive(0, 0, 2, 1);
      drain(2);

      // reset mid-stream with a pending event and pop
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, i + 1, 0);
      step(1, 1, 7, 1);
      sync();
      check("mid_rst_count", int'(count), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_ovf",   int'(overflow), 0);
      drive(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 4, 0);
      sync();
      check("post_rst_dt", int'(out_dt), 3);
      drive(0, 0, 4, 1);
      drain(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         v = $urandom_range(0, 99);
         if (v < 1) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
         end else if (v < 6) begin
            step(0, 1, 5, $urandom_range(0, 1));
            step(0, 1, 6, $urandom_range(0, 1));
            step(0, 1, 3, $urandom_range(0, 1));
         end else begin
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : int'(saida);
            step(0, ($urandom_range(0, 3) != 0) ? 1 : 0, s, ($urandom_range(0, 2) != 0) ? 1 : 0);
         end
      end
      drain(DEPTH + 2);
      sync();
      check("final_empty", int'(count), 0);
      check("final_queue", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/saida_tracer.md
# saida_tracer

Downstream monitor for the 3-bit `saida` state code produced by the FSM stage. It samples the code every enabled cycle and detects changes. Each change is logged as an {code, interval} entry in a small FIFO, which a consumer drains through a valid/ready port. It also flags the 5→6→3 code sequence (the repeated a=3 path).

## Interface
- `DEPTH`, default 8: number of FIFO entries; must be a power of 2 and ≥ 2.
- `CODE_W`, default 3: width of the incoming state code.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `saida`  in  CODE_W  state code from the upstream FSM, sampled every rising edge.
- `en`  in  1  capture enable; when 0 the block ignores `saida` and holds the previous code and interval counter.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_valid`  out  1  FIFO non-empty; head entry is presented.
- `out_code`  out  CODE_W  code of the head entry; 0 when `out_valid`=0.
- `out_dt`  out  8  interval of the head entry; 0 when `out_valid`=0.
- `count`  out  log2(DEPTH)+1  current number of stored entries.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.
- `seq_hit`  out  1  one-cycle pulse after the event sequence 5, 6, 3.

## Operation
- Registers `prev` (CODE_W) and `cnt` (8 bits), both 0 after reset. 0 matches the FSM reset state.
- Event: `en`=1 and `saida` ≠ `prev`. No events are possible while `en`=0.
- Each edge with `en`=1:
  - `prev` ← `saida`.
  - On an event: the entry {`saida`, sat(`cnt`+1)} is generated and `cnt` ← 0.
  - Otherwise: `cnt` ← sat(`cnt`+1).
  - sat() saturates at 255; the counter never wraps.
- `out_dt` is therefore the number of enabled cycles since the previous event (or since reset), including the event cycle.
- Push: an event occurs and either (`count` < DEPTH) or (`count` = DEPTH and a pop happens in the same cycle).
- Drop: an event occurs with `count` = DEPTH and no pop. The entry is discarded and `overflow` ← 1 until reset.
- Pop: `out_valid` && `out_ready`. `out_ready` is ignored when empty.
- Simultaneous push and pop: `count` is unchanged, and order is preserved (FIFO).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by `count`.
- Sequence detector:
  - Holds the codes of the last two events (reset to 0). Dropped events still count.
  - When an event with code 3 follows events 5 then 6 (consecutive events), `seq_hit` = 1 for exactly the next cycle.
  - Overlapping sequences are allowed.
- `reset`=1 at any edge, mid-stream included:
  - Flushes the FIFO: `count`=0, pointers 0.
  - Clears `prev`, `cnt`, `overflow`, `seq_hit` and the detector history.
  - Discards any push or pop requested that cycle.
- Reset values: `out_valid`=0, `out_code`=0, `out_dt`=0, `count`=0, `overflow`=0, `seq_hit`=0.

## Timing
- Event at edge N → entry visible at `out_valid`/`out_code`/`out_dt` after edge N. There is no combinational bypass from `saida` to the outputs.
- Pop at edge N → the next head (or `out_valid`=0) is presented after edge N.
- `count`, `overflow` and `seq_hit` are registered and update at the same edge as the event or pop that causes them.
- `out_code` and `out_dt` are combinational from the head storage plus `out_valid` gating; no extra latency.
- Full throughput: one push and one pop per cycle are sustained indefinitely.

## Test plan
- **Reset and first events.** Hold `reset` 2 cycles, then `en`=1 with `saida` = 0,0,0,1. Required: `out_valid` rises after the 4th edge with `out_code`=1, `out_dt`=4, `count`=1; all outputs 0 during reset.
- **Sequence detection.** `saida` steps 0→5→6→3 on consecutive cycles. Required: 3 entries {5,1},{6,1},{3,1}, and one `seq_hit` pulse after the edge that logged 3. A following 5,6,3 gives a second pulse.
- **Overflow.** `out_ready`=0, DEPTH=8, generate 9 changes. Required: `count`=8, `overflow`=1, the 9th entry absent. Draining returns the first 8 in order, and `overflow` stays 1.
- **Simultaneous push and pop while full.** FIFO full, `out_ready`=1, one event. Required: `count` stays 8, `overflow` stays 0, the oldest entry is popped and the new entry lands at the tail.
- **Interval counting.** Toggle `en` 0/1 while `saida` is constant for 300 enabled cycles, then change. Required: `out_dt`=255 (saturated). Cycles with `en`=0 are not counted and raise no event, even if `saida` changes.
- **Reset mid-stream.** Assert `reset` with 5 entries stored and a pending event in the same cycle. Required: `count`=0, `out_valid`=0, `overflow`=0 after the edge. The next change from 0 logs `out_dt` counted from reset.
